lstm_seq_ctrl: RTL and testbench

//  Time-step sequencer on the far side of the lstm_cell interface: accepts an input

---
 rtl/lstm_seq_ctrl_if.sv | 42 ++++
 rtl/lstm_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lstm_seq_ctrl_if.sv
// Bundle of every signal between the LSTM time-step sequencer and its
// neighbours.
//   x_*      : input step stream (valid/ready, with last marker)
//   cell_*   : drive to and return from the lstm_cell datapath
//   h_*      : output hidden-state stream (valid/ready, with last marker)
//   step_cnt : index of the step in flight
//   seq_err  : sticky flag, a sequence overran MAX_STEPS
// The controller uses the slave modport. The environment (source, cell and
// sink) uses the master modport.
interface lstm_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_W     = 6
);
  logic                         x_valid;
  logic                         x_ready;
  logic signed [DATA_WIDTH-1:0] x_data;
  logic                         x_last;
  logic signed [DATA_WIDTH-1:0] cell_x;
  logic signed [DATA_WIDTH-1:0] cell_c;
  logic signed [DATA_WIDTH-1:0] cell_h;
  logic                         cell_start;
  logic signed [DATA_WIDTH-1:0] cell_c_out;
  logic signed [DATA_WIDTH-1:0] cell_h_out;
  logic                         h_valid;
  logic                         h_ready;
  logic signed [DATA_WIDTH-1:0] h_data;
  logic                         h_last;
  logic [STEP_W-1:0]            step_cnt;
  logic                         seq_err;

  modport master (
    output x_valid, x_data, x_last, cell_c_out, cell_h_out, h_ready,
    input  x_ready, cell_x, cell_c, cell_h, cell_start,
           h_valid, h_data, h_last, step_cnt, seq_err
  );

  modport slave (
    input  x_valid, x_data, x_last, cell_c_out, cell_h_out, h_ready,
    output x_ready, cell_x, cell_c, cell_h, cell_start,
           h_valid, h_data, h_last, step_cnt, seq_err
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// LSTM time-step sequencer. The sequencer accepts one X[t] at a time and
// presents it to the cell together with the recurrent state c/h. It waits
// CELL_LAT cycles, then captures the new c/h. It then offers h[t] downstream
// and holds it until the downstream side accepts it. At the end of a sequence
// it clears the recurrent state to zero. Data passes through bit-exact.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : lstm_seq_ctrl_if.slave (x stream, cell drive/return, h stream,
//         step_cnt, seq_err)
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int CELL_LAT    = 2,
  parameter int MAX_STEPS   = 64
) (
  input logic            clk,
  input logic            rst,
  lstm_seq_ctrl_if.slave bus
);
  localparam int STEP_W = $clog2(MAX_STEPS);

  // The Q format is only carried through. It is checked here so that an
  // illegal configuration fails at elaboration.
  if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH || CELL_LAT < 1 || CELL_LAT > 15)
  begin : g_bad_param
    $error("lstm_seq_ctrl: illegal FRACT_WIDTH or CELL_LAT");
  end

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, OUT} state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   lat_cnt;
  logic                         last_q;
  logic                         accept;
  logic                         h_fire;
  logic                         at_max;
  logic signed [DATA_WIDTH-1:0] c_reg;
  logic signed [DATA_WIDTH-1:0] h_reg;

  assign at_max = (bus.step_cnt == STEP_W'(MAX_STEPS - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    h_fire    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.x_valid;
        if (accept) state_nxt = WAIT;
      end
      WAIT: if (lat_cnt == 4'd1) state_nxt = CAPT;
      CAPT: state_nxt = OUT;
      OUT: begin
        h_fire = bus.h_ready;
        if (h_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // x_ready is gated by rst so that it reads low for the whole reset pulse.
  assign bus.x_ready    = (state == IDLE) && !rst;
  // lat_cnt still holds its load value only in the first WAIT cycle.
  assign bus.cell_start = (state == WAIT) && (lat_cnt == 4'(CELL_LAT));
  assign bus.h_valid    = (state == OUT);
  assign bus.cell_c     = c_reg;
  assign bus.cell_h     = h_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Control: latency counter, last flag, step index, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt      <= '0;
      last_q       <= 1'b0;
      bus.h_last   <= 1'b0;
      bus.step_cnt <= '0;
      bus.seq_err  <= 1'b0;
    end else begin
      if (accept) begin
        lat_cnt <= 4'(CELL_LAT);
        // The final slot of a full-length sequence ends that sequence.
        // step_cnt therefore never wraps.
        last_q  <= bus.x_last | at_max;
        if (at_max && !bus.x_last) bus.seq_err <= 1'b1;
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (state == CAPT) bus.h_last <= last_q;
      if (h_fire) begin
        bus.h_last <= 1'b0;
        if (last_q) bus.step_cnt <= '0;
        else        bus.step_cnt <= bus.step_cnt + STEP_W'(1);
      end
    end
  end

  // Data: cell input latch, recurrent state, output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cell_x <= '0;
      c_reg      <= '0;
      h_reg      <= '0;
      bus.h_data <= '0;
    end else begin
      if (accept) bus.cell_x <= bus.x_data;
      if (state == CAPT) begin
        c_reg      <= bus.cell_c_out;
        h_reg      <= bus.cell_h_out;
        bus.h_data <= bus.cell_h_out;
      end
      if (h_fire && last_q) begin
        c_reg <= '0;
        h_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
module tb_lstm_seq_ctrl;
  localparam int CELL_LAT = 2;

  typedef struct {
    logic signed [15:0] x;
    logic               last;
    int                 bp;
    logic               hold;
    logic signed [15:0] exp_cin;
    logic signed [15:0] exp_hin;
    logic signed [15:0] exp_h;
    logic               exp_last;
    logic [1:0]         exp_step;
    logic               exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   mcnt = 0;
  logic signed [15:0] mc, mh;
  vec_t vecs[10];
  vec_t pre;

  lstm_seq_ctrl_if #(.DATA_WIDTH(16), .STEP_W(2)) bus ();

  lstm_seq_ctrl #(
    .DATA_WIDTH(16), .FRACT_WIDTH(8), .CELL_LAT(CELL_LAT), .MAX_STEPS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.cell_start) starts <= starts + 1;

  // Cell model: c' = (x>>>1)+c, h' = (x>>>2)+h. The model samples its inputs
  // on the cell_start edge and returns the result CELL_LAT cycles later.
  // It drives junk at all other times.
  always @(posedge clk) begin
    bus.cell_c_out <= 16'sh5EAD;
    bus.cell_h_out <= 16'sh3EEF;
    if (bus.cell_start) begin
      mc   <= (bus.cell_x >>> 1) + bus.cell_c;
      mh   <= (bus.cell_x >>> 2) + bus.cell_h;
      mcnt <= CELL_LAT - 1;
    end else if (mcnt == 1) begin
      bus.cell_c_out <= mc;
      bus.cell_h_out <= mh;
      mcnt <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_step(input vec_t v, input int idx);
    int cyc;
    int s0;
    logic signed [15:0] hd;
    logic hl;
    cyc = 0;
    while (!bus.x_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("v%0d idle_ready", idx), 32'(bus.x_ready), 32'd1);
    bus.x_valid = 1'b1;
    bus.x_data  = v.x;
    bus.x_last  = v.last;
    bus.h_ready = (v.bp == 0);
    s0 = starts;
    @(posedge clk); #1;
    if (!v.hold) begin
      bus.x_valid = 1'b0;
      bus.x_data  = 16'sh5A5A;
      bus.x_last  = 1'b0;
    end
    chk($sformatf("v%0d cell_start", idx), 32'(bus.cell_start), 32'd1);
    chk($sformatf("v%0d cell_x", idx), 32'(bus.cell_x), 32'(v.x));
    chk($sformatf("v%0d cell_c", idx), 32'(bus.cell_c), 32'(v.exp_cin));
    chk($sformatf("v%0d cell_h", idx), 32'(bus.cell_h), 32'(v.exp_hin));
    chk($sformatf("v%0d busy_ready", idx), 32'(bus.x_ready), 32'd0);
    cyc = 0;
    while (!bus.h_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(CELL_LAT + 1));
    chk($sformatf("v%0d h_data", idx), 32'(bus.h_data), 32'(v.exp_h));
    chk($sformatf("v%0d h_last", idx), 32'(bus.h_last), 32'(v.exp_last));
    chk($sformatf("v%0d step_cnt", idx), 32'(bus.step_cnt), 32'(v.exp_step));
    chk($sformatf("v%0d seq_err", idx), 32'(bus.seq_err), 32'(v.exp_err));
    chk($sformatf("v%0d cell_x_held", idx), 32'(bus.cell_x), 32'(v.x));
    if (v.bp > 0) begin
      hd = bus.h_data;
      hl = bus.h_last;
      repeat (v.bp) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d bp_valid", idx), 32'(bus.h_valid), 32'd1);
        chk($sformatf("v%0d bp_data", idx), 32'(bus.h_data), 32'(hd));
        chk($sformatf("v%0d bp_last", idx), 32'(bus.h_last), 32'(hl));
        chk($sformatf("v%0d bp_ready", idx), 32'(bus.x_ready), 32'd0);
      end
      bus.h_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    chk($sformatf("v%0d h_valid_drop", idx), 32'(bus.h_valid), 32'd0);
    chk($sformatf("v%0d one_start", idx), 32'(starts - s0), 32'd1);
    if (v.exp_last) begin
      chk($sformatf("v%0d clr_c", idx), 32'(bus.cell_c), 32'd0);
      chk($sformatf("v%0d clr_h", idx), 32'(bus.cell_h), 32'd0);
      chk($sformatf("v%0d clr_step", idx), 32'(bus.step_cnt), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int seen;
    //        x          last bp  hold cin        hin        h          last step err
    vecs[0] = '{16'sh0100, 1'b1, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0040, 1'b1, 2'd0, 1'b0};
    vecs[1] = '{16'sh0040, 1'b0, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0010, 1'b0, 2'd0, 1'b0};
    vecs[2] = '{16'sh0080, 1'b0, 10, 1'b0, 16'sh0020, 16'sh0010, 16'sh0030, 1'b0, 2'd1, 1'b0};
    vecs[3] = '{16'shFF00, 1'b1, 0,  1'b1, 16'sh0060, 16'sh0030, 16'shFFF0, 1'b1, 2'd2, 1'b0};
    vecs[4] = '{16'sh0200, 1'b1, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0080, 1'b1, 2'd0, 1'b0};
    vecs[5] = '{16'sh0004, 1'b0, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0001, 1'b0, 2'd0, 1'b0};
    vecs[6] = '{16'sh0004, 1'b0, 0,  1'b1, 16'sh0002, 16'sh0001, 16'sh0002, 1'b0, 2'd1, 1'b0};
    vecs[7] = '{16'sh0004, 1'b0, 0,  1'b0, 16'sh0004, 16'sh0002, 16'sh0003, 1'b0, 2'd2, 1'b0};
    vecs[8] = '{16'sh0004, 1'b0, 0,  1'b0, 16'sh0006, 16'sh0003, 16'sh0004, 1'b1, 2'd3, 1'b1};
    vecs[9] = '{16'sh0100, 1'b1, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0040, 1'b1, 2'd0, 1'b1};
    pre     = '{16'sh0040, 1'b0, 0,  1'b0, 16'sh0000, 16'sh0000, 16'sh0010, 1'b0, 2'd0, 1'b0};

    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.x_last  = 1'b0;
    bus.h_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst x_ready", 32'(bus.x_ready), 32'd0);
    chk("rst h_valid", 32'(bus.h_valid), 32'd0);
    chk("rst cell_start", 32'(bus.cell_start), 32'd0);
    chk("rst step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("rst seq_err", 32'(bus.seq_err), 32'd0);
    chk("rst cell_c", 32'(bus.cell_c), 32'd0);
    chk("rst h_data", 32'(bus.h_data), 32'd0);
    chk("rst h_last", 32'(bus.h_last), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst x_ready", 32'(bus.x_ready), 32'd1);

    // Build up a non-zero state, then reset in the middle of WAIT.
    run_step(pre, 99);
    chk("pre step_cnt", 32'(bus.step_cnt), 32'd1);
    bus.x_valid = 1'b1;
    bus.x_data  = 16'sh0080;
    bus.x_last  = 1'b0;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    chk("midrst cell_start", 32'(bus.cell_start), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst h_valid", 32'(bus.h_valid), 32'd0);
    chk("midrst cell_start0", 32'(bus.cell_start), 32'd0);
    chk("midrst step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("midrst cell_c", 32'(bus.cell_c), 32'd0);
    chk("midrst cell_h", 32'(bus.cell_h), 32'd0);
    chk("midrst cell_x", 32'(bus.cell_x), 32'd0);
    chk("midrst x_ready", 32'(bus.x_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s0 = starts;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.h_valid) seen++;
    end
    chk("midrst no_output", 32'(seen), 32'd0);
    chk("midrst no_start", 32'(starts - s0), 32'd0);

    for (int i = 0; i < 10; i++) run_step(vecs[i], i);

    chk("end seq_err sticky", 32'(bus.seq_err), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
